// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_pkg
// Brief    : Shared FSM encoding, port IDs and timeout default for the arbiter
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin arbiter sharing one memory port between IF and data
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic [3:0]  if_sel_n,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we_n,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel_n,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we_n,
  output logic [3:0]  mem_sel_n,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam int c_TIMER_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_start;
  logic                   w_complete;
  logic                   w_expire;
  logic                   w_pick;
  logic                   w_busy;
  logic                   r_grant;
  logic                   r_last_grant;
  logic [c_TIMER_W-1:0]   r_timer;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;
  logic                   r_we_n;
  logic [3:0]             r_sel_n;
  logic [31:0]            r_if_rdata;
  logic                   r_if_err;
  logic [31:0]            r_d_rdata;
  logic                   r_d_err;
  logic [31:0]            w_result;

  // Ties go to whichever port was not served last.
  always_comb begin
    if (if_req && d_req) w_pick = ~r_last_grant;
    else if (d_req)      w_pick = PORT_D;
    else                 w_pick = PORT_IF;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_complete  = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (if_req || d_req) begin
          w_start     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A completion on the final allowed cycle wins over the timeout.
        if (mem_done) begin
          w_complete  = 1'b1;
          w_state_nxt = DONE;
        end else if (r_timer == c_TIMER_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_result = (w_complete && r_we_n) ? mem_rdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= PORT_IF;
      r_last_grant <= PORT_IF;
      r_timer      <= '0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_we_n       <= 1'b1;
      r_sel_n      <= 4'hF;
      r_if_rdata   <= 32'h0;
      r_if_err     <= 1'b0;
      r_d_rdata    <= 32'h0;
      r_d_err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        r_timer      <= '0;
        if (w_pick == PORT_D) begin
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
          r_we_n  <= d_we_n;
          r_sel_n <= d_sel_n;
        end else begin
          r_addr  <= if_addr;
          r_wdata <= 32'h0;
          r_we_n  <= 1'b1;
          r_sel_n <= if_sel_n;
        end
      end else if (w_busy && !mem_done) begin
        r_timer <= r_timer + c_TIMER_W'(1);
      end

      if (w_complete || w_expire) begin
        if (r_grant == PORT_D) begin
          r_d_rdata <= w_result;
          r_d_err   <= w_expire;
        end else begin
          r_if_rdata <= w_result;
          r_if_err   <= w_expire;
        end
      end
    end
  end

  // The bus is parked at its reset values whenever no transaction is active.
  assign w_busy    = (r_state == BUSY);
  assign mem_en    = w_busy;
  assign mem_addr  = w_busy ? r_addr  : 32'h0;
  assign mem_wdata = w_busy ? r_wdata : 32'h0;
  assign mem_we_n  = w_busy ? r_we_n  : 1'b1;
  assign mem_sel_n = w_busy ? r_sel_n : 4'hF;

  assign if_done  = (r_state == DONE) && (r_grant == PORT_IF);
  assign d_done   = (r_state == DONE) && (r_grant == PORT_D);
  assign if_rdata = r_if_rdata;
  assign if_err   = r_if_err;
  assign d_rdata  = r_d_rdata;
  assign d_err    = r_d_err;

endmodule
`default_nettype wire
